// File: rtl/obj_pkg.sv
// obj_pkg: object record layout, type/op codes and colours shared by the object-list writer and renderer
package obj_pkg;
  localparam int ENUM_L = 65, ENUM_R = 62;
  localparam int X_L = 61, X_R = 52;
  localparam int Y_L = 51, Y_R = 42;
  localparam int WIDTH_L = 41, WIDTH_R = 32;
  localparam int HEIGHT_L = 31, HEIGHT_R = 22;
  localparam int RADIUS_L = 21, RADIUS_R = 12;
  localparam int COLOR_L = 11, COLOR_R = 0;
  localparam logic [3:0] RECT = 4'd0, CIRCLE = 4'd1, RRECT = 4'd2;
  typedef enum logic [1:0] {OP_ADD, OP_SET, OP_CLEAR, OP_COMMIT} op_e;
  localparam logic [11:0] BLACK = 12'h000, WHITE = 12'hfff, RED = 12'hf00, GREEN = 12'h0f0, BLUE = 12'h00f;
endpackage

// File: rtl/obj_table_writer.sv
// obj_table_writer: edits a shadow object table and copies it to the active table at the start of vblank
module obj_table_writer
  import obj_pkg::*;
#(
  parameter int OBJ_WIDTH = 66,
  parameter int MAX_LEN = 16,
  parameter int LEN_BITS = 6
) (
  input  logic                          rst,
  input  logic                          clk25,
  input  logic                          vblank,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [LEN_BITS-1:0]           cmd_idx,
  input  logic [OBJ_WIDTH-1:0]          cmd_obj,
  output logic [OBJ_WIDTH*MAX_LEN-1:0]  obj_arr_packed,
  output logic [LEN_BITS-1:0]           obj_arr_len,
  output logic                          commit_pending,
  output logic                          commit_done,
  output logic                          err
);
  localparam logic [LEN_BITS-1:0] MAX = LEN_BITS'(MAX_LEN);
  logic [OBJ_WIDTH-1:0] shadow [MAX_LEN];
  logic [OBJ_WIDTH-1:0] active [MAX_LEN];
  logic [LEN_BITS-1:0] shadow_len;
  logic vblank_d, copy, fire, is_add, is_set, add_ok, set_ok;
  assign copy = commit_pending && vblank && !vblank_d;
  assign cmd_ready = !copy;
  assign fire = cmd_valid && cmd_ready;
  assign is_add = fire && cmd_op == OP_ADD;
  assign is_set = fire && cmd_op == OP_SET;
  assign add_ok = shadow_len < MAX;
  assign set_ok = cmd_idx < MAX;
  always_ff @(posedge clk25 or negedge rst)
    if (!rst) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        shadow[j] <= '0;
        active[j] <= '0;
      end
      shadow_len <= '0;
      obj_arr_len <= '0;
      commit_pending <= 1'b0;
      commit_done <= 1'b0;
      err <= 1'b0;
      vblank_d <= 1'b0;
    end else begin
      vblank_d <= vblank;
      commit_done <= copy;
      err <= (is_add && !add_ok) || (is_set && !set_ok);
      for (int j = 0; j < MAX_LEN; j++) begin
        if ((is_add && add_ok && shadow_len == LEN_BITS'(j)) || (is_set && cmd_idx == LEN_BITS'(j)))
          shadow[j] <= cmd_obj;
        if (copy) active[j] <= shadow[j];
      end
      if (copy) begin
        obj_arr_len <= shadow_len;
        commit_pending <= 1'b0;
      end else if (fire && cmd_op == OP_COMMIT) commit_pending <= 1'b1;
      if (is_add && add_ok) shadow_len <= shadow_len + 1'b1;
      else if (fire && cmd_op == OP_CLEAR) shadow_len <= '0;
    end
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_pack
    assign obj_arr_packed[i*OBJ_WIDTH +: OBJ_WIDTH] = active[i];
  end
endmodule

// File: tb/tb_obj_table_writer.sv
// tb_obj_table_writer: randomized + directed scoreboard bench against a table-level reference model
module tb_obj_table_writer;
  import obj_pkg::*;
  localparam int W = 66, N = 16, LB = 6;
  logic rst, clk25, vblank, cmd_valid, cmd_ready, commit_pending, commit_done, err;
  logic [1:0] cmd_op;
  logic [LB-1:0] cmd_idx, obj_arr_len;
  logic [W-1:0] cmd_obj;
  logic [W*N-1:0] obj_arr_packed;
  obj_table_writer #(.OBJ_WIDTH(W), .MAX_LEN(N), .LEN_BITS(LB)) dut (
    .rst(rst), .clk25(clk25), .vblank(vblank), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_obj(cmd_obj), .obj_arr_packed(obj_arr_packed),
    .obj_arr_len(obj_arr_len), .commit_pending(commit_pending), .commit_done(commit_done), .err(err));
  typedef struct {int cyc; logic [W*N-1:0] tab; int len;} snap_t;
  snap_t commit_q[$];
  int err_q[$];
  logic [W-1:0] m_shadow [N];
  logic [W-1:0] m_act [N];
  int m_len, m_act_len, cyc;
  bit m_pending, m_vbd;
  int checks, errors;
  initial clk25 = 0;
  always #20 clk25 = ~clk25;
  function automatic logic [W*N-1:0] pack_act();
    logic [W*N-1:0] p;
    for (int k = 0; k < N; k++) p[k*W +: W] = m_act[k];
    return p;
  endfunction
  function automatic logic [W-1:0] mk(logic [3:0] t, int x, int y, logic [11:0] c);
    logic [W-1:0] o;
    o = '0;
    o[ENUM_L:ENUM_R] = t;
    o[X_L:X_R] = 10'(x);
    o[Y_L:Y_R] = 10'(y);
    o[COLOR_L:COLOR_R] = c;
    return o;
  endfunction
  function automatic logic [W-1:0] rnd_obj();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction
  task automatic chk(string name, logic [W*N-1:0] act, logic [W*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    m_len = 0; m_act_len = 0; m_pending = 0; m_vbd = 0; cyc = 0;
    for (int k = 0; k < N; k++) begin m_shadow[k] = '0; m_act[k] = '0; end
    forever begin
      @(posedge clk25 or negedge rst);
      if (!rst) begin
        m_len = 0; m_act_len = 0; m_pending = 0; m_vbd = 0;
        for (int k = 0; k < N; k++) begin m_shadow[k] = '0; m_act[k] = '0; end
        commit_q.delete();
        err_q.delete();
      end else if (clk25) begin
        cyc++;
        if (m_pending && vblank && !m_vbd) begin
          for (int k = 0; k < N; k++) m_act[k] = m_shadow[k];
          m_act_len = m_len;
          m_pending = 0;
          commit_q.push_back('{cyc, pack_act(), m_act_len});
        end else if (cmd_valid) begin
          case (cmd_op)
            OP_ADD: if (m_len < N) begin m_shadow[m_len] = cmd_obj; m_len++; end else err_q.push_back(cyc);
            OP_SET: if (int'(cmd_idx) < N) m_shadow[cmd_idx] = cmd_obj; else err_q.push_back(cyc);
            OP_CLEAR: m_len = 0;
            default: m_pending = 1;
          endcase
        end
        m_vbd = vblank;
      end
    end
  end
  initial forever begin
    @(negedge clk25);
    if (rst) begin
      snap_t s;
      chk("cmd_ready", W*N'(cmd_ready), W*N'(!(m_pending && vblank && !m_vbd)));
      chk("commit_pending", W*N'(commit_pending), W*N'(m_pending));
      chk("obj_arr_len", W*N'(obj_arr_len), W*N'(m_act_len));
      chk("obj_arr_packed", obj_arr_packed, pack_act());
      if (commit_q.size() > 0 && commit_q[0].cyc == cyc) begin
        s = commit_q.pop_front();
        chk("commit_done", W*N'(commit_done), W*N'(1));
        chk("commit_len", W*N'(obj_arr_len), W*N'(s.len));
        chk("commit_table", obj_arr_packed, s.tab);
      end else chk("commit_done_idle", W*N'(commit_done), W*N'(0));
      if (err_q.size() > 0 && err_q[0] == cyc) begin
        void'(err_q.pop_front());
        chk("err", W*N'(err), W*N'(1));
      end else chk("err_idle", W*N'(err), W*N'(0));
    end
  end
  task automatic idle(int n);
    repeat (n) begin @(negedge clk25); cmd_valid = 0; end
  endtask
  task automatic set_vb(bit v);
    @(negedge clk25);
    cmd_valid = 0;
    vblank = v;
  endtask
  task automatic vb_pulse();
    set_vb(0); set_vb(1); idle(2); set_vb(0); idle(1);
  endtask
  task automatic send(logic [1:0] op, int idx, logic [W-1:0] obj);
    int n;
    @(negedge clk25);
    cmd_valid = 1; cmd_op = op; cmd_idx = LB'(idx); cmd_obj = obj;
    #1;
    n = 0;
    while (!cmd_ready && n < 8) begin @(negedge clk25); #1; n++; end
    if (!cmd_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout: cmd_ready=0 expected 1 within 8 cycles");
      cmd_valid = 0;
    end else @(posedge clk25);
  endtask
  logic [W-1:0] oa, ob, oc, last;
  initial begin
    checks = 0; errors = 0;
    rst = 0; vblank = 0; cmd_valid = 0; cmd_op = 0; cmd_idx = 0; cmd_obj = '0;
    repeat (3) @(posedge clk25);
    #2 rst = 1;
    #1 chk("reset_len", W*N'(obj_arr_len), '0);
    chk("reset_table", obj_arr_packed, '0);
    oa = mk(RECT, 100, 100, GREEN);
    ob = mk(CIRCLE, 200, 50, RED);
    send(OP_ADD, 0, oa); send(OP_ADD, 0, ob); idle(3);
    chk("pre_commit_len", W*N'(obj_arr_len), '0);
    chk("pre_commit_table", obj_arr_packed, '0);
    send(OP_COMMIT, 0, '0); idle(2); vb_pulse();
    chk("t1_len", W*N'(obj_arr_len), W*N'(2));
    chk("t1_e0", W*N'(obj_arr_packed[0 +: W]), W*N'(oa));
    chk("t1_e1", W*N'(obj_arr_packed[W +: W]), W*N'(ob));
    send(OP_CLEAR, 0, '0);
    for (int k = 0; k < 16; k++) begin last = rnd_obj(); send(OP_ADD, 0, last); end
    send(OP_ADD, 0, rnd_obj()); idle(2);
    send(OP_COMMIT, 0, '0); vb_pulse();
    chk("t2_len", W*N'(obj_arr_len), W*N'(16));
    chk("t2_e15", W*N'(obj_arr_packed[15*W +: W]), W*N'(last));
    send(OP_CLEAR, 0, '0); send(OP_ADD, 0, oa); send(OP_ADD, 0, ob);
    oc = mk(RRECT, 7, 9, BLUE);
    send(OP_SET, 20, rnd_obj()); send(OP_SET, 5, oc); idle(2);
    send(OP_COMMIT, 0, '0); vb_pulse();
    chk("t3_len", W*N'(obj_arr_len), W*N'(2));
    chk("t3_e5", W*N'(obj_arr_packed[5*W +: W]), W*N'(oc));
    set_vb(1); idle(2);
    send(OP_COMMIT, 0, '0); idle(4);
    chk("t4_waiting", W*N'(commit_pending), W*N'(1));
    set_vb(0); idle(2); set_vb(1); idle(2); set_vb(0);
    chk("t4_done", W*N'(commit_pending), W*N'(0));
    send(OP_CLEAR, 0, '0); send(OP_ADD, 0, oa); send(OP_COMMIT, 0, '0); idle(2);
    @(negedge clk25);
    vblank = 1; cmd_valid = 1; cmd_op = OP_ADD; cmd_obj = oc;
    #1 chk("t5_ready_low", W*N'(cmd_ready), W*N'(0));
    @(negedge clk25);
    #1 chk("t5_ready_high", W*N'(cmd_ready), W*N'(1));
    idle(2);
    chk("t5_active_len", W*N'(obj_arr_len), W*N'(1));
    set_vb(0); send(OP_COMMIT, 0, '0); vb_pulse();
    chk("t5_after_len", W*N'(obj_arr_len), W*N'(2));
    chk("t5_after_e1", W*N'(obj_arr_packed[W +: W]), W*N'(oc));
    send(OP_CLEAR, 0, '0);
    for (int k = 0; k < 3; k++) send(OP_ADD, 0, rnd_obj());
    send(OP_COMMIT, 0, '0); vb_pulse(); send(OP_COMMIT, 0, '0); idle(1);
    @(posedge clk25);
    #2 rst = 0;
    #1 chk("t6_len", W*N'(obj_arr_len), '0);
    chk("t6_table", obj_arr_packed, '0);
    chk("t6_pending", W*N'(commit_pending), '0);
    @(posedge clk25);
    #2 rst = 1;
    vb_pulse();
    for (int k = 0; k < 1500; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45) send(OP_ADD, 0, rnd_obj());
      else if (r < 65) send(OP_SET, $urandom_range(0, 20), rnd_obj());
      else if (r < 72) send(OP_CLEAR, 0, '0);
      else if (r < 82) send(OP_COMMIT, 0, '0);
      else if (r < 92) set_vb(~vblank);
      else idle(1);
    end
    set_vb(0); idle(3);
    checks++;
    if (commit_q.size() != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: commit_q=%0d err_q=%0d expected 0", commit_q.size(), err_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/obj_table_writer.md
Name: obj_table_writer

Overview:
- Writer end of the object-list interface that feeds basic_graph.
- Accepts add/set/clear/commit commands from game or keyboard logic through a valid/ready handshake and edits a private shadow table.
- Copies the shadow table to the active table (obj_arr_packed / obj_arr_len) only at the start of vertical blanking, so the renderer never shows a half-edited frame.

Parameters:
- OBJ_WIDTH, 66, bits per object record {type[65:62], x[61:52], y[51:42], w[41:32], h[31:22], r[21:12], color[11:0]}
- MAX_LEN, 16, number of table entries
- LEN_BITS, 6, width of length and index fields; must satisfy 2^LEN_BITS > MAX_LEN

Ports:
- rst  in  1  asynchronous reset, active-low
- clk25  in  1  25 MHz pixel clock; all logic on its rising edge
- vblank  in  1  level, high while the VGA driver is outside the visible area
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  0=ADD, 1=SET, 2=CLEAR, 3=COMMIT
- cmd_idx  in  LEN_BITS  target index for SET; ignored for other ops
- cmd_obj  in  OBJ_WIDTH  object record for ADD/SET
- obj_arr_packed  out  OBJ_WIDTH*MAX_LEN  active table; entry i at bits [(i+1)*OBJ_WIDTH-1 : i*OBJ_WIDTH]
- obj_arr_len  out  LEN_BITS  active object count
- commit_pending  out  1  a COMMIT is accepted but not yet applied
- commit_done  out  1  one-cycle pulse in the cycle the active table updates
- err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (rst low, asynchronous):
  - All shadow and active entries = 0.
  - shadow_len = 0, obj_arr_len = 0.
  - commit_pending, commit_done, err = 0; vblank_d = 0.
- vblank_d registers vblank. vb_rise = vblank && !vblank_d.
- cmd_ready = !(commit_pending && vb_rise). It is combinational and low only in the copy cycle, so a command is never accepted in the same cycle as a copy.
- Accepted commands; each takes effect on the next edge and is visible in the shadow table one cycle after acceptance:
  - ADD:
    - If shadow_len < MAX_LEN: shadow[shadow_len] <= cmd_obj; shadow_len += 1.
    - Otherwise: no change; err pulses the next cycle.
  - SET:
    - If cmd_idx < MAX_LEN: shadow[cmd_idx] <= cmd_obj; shadow_len unchanged, including when cmd_idx >= shadow_len.
    - Otherwise: no change; err pulses.
  - CLEAR: shadow_len <= 0. Entry contents are retained.
  - COMMIT: commit_pending <= 1. A COMMIT while already pending is accepted with no additional effect.
- Copy cycle (commit_pending && vb_rise):
  - Active entries <= shadow entries; obj_arr_len <= shadow_len.
  - commit_pending <= 0; commit_done = 1 for that cycle, registered together with the copy.
  - A commit requested while vblank is already high waits for the next rising edge.
- Latency: COMMIT accepted at cycle t with vblank low → copy at the first vb_rise after t. Active outputs change only in copy cycles and on reset.
- The active table and length are registered outputs and stay stable for an entire visible frame.
- Edits after COMMIT but before the copy are included in the copy; the shadow table is snapshotted only at vb_rise.
- Reset mid-operation discards the pending commit and both tables.
- err and commit_done never assert in the same cycle. Cause: a rejected command needs cmd_ready high, which is false in the copy cycle.

Decomposition:
- Package obj_pkg holds:
  - the field bit positions (ENUM/X/Y/WIDTH/HEIGHT/RADIUS/COLOR left/right);
  - the type codes RECT=0, CIRCLE=1, RRECT=2;
  - the op codes OP_ADD/OP_SET/OP_CLEAR/OP_COMMIT;
  - the colour constants.
- basic_graph takes its field bit positions from the same package.
- No sub-module. The edge detector and the table registers are inline, since the table is one generate loop.

Test Plan:
- Reset, then ADD A (x=100, y=100, color=12'h0f0) and ADD B with vblank=0 → obj_arr_len stays 0 and obj_arr_packed stays all zero. Then COMMIT and raise vblank → commit_done pulses once, len=2, entry0=A, entry1=B.
- 16 ADDs then a 17th ADD → err pulses once on the 17th, shadow_len=16. After commit, len=16 and entry15 = the 16th object.
- SET idx=20 → err. SET idx=5 while len=2 → no err. After commit len stays 2 and entry5 holds the new object.
- COMMIT with vblank already high → no copy. Copy happens only after vblank falls and rises again, with commit_pending=1 in between.
- cmd_valid held high with ADD on the vb_rise cycle of a pending commit → cmd_ready=0 that cycle. The ADD is accepted the next cycle, is not in the active table, and appears after the next commit.
- Assert rst with commit_pending=1 and len=3 → outputs zero immediately (async). A later vb_rise produces no commit_done.
